// File: rtl/mem_stage_unit_pkg.sv
// Shared types for the MEM stage: FSM state encoding, MEM/WB field widths and
// the latched memory request / MEM/WB register layouts.
package mem_stage_unit_pkg;

  localparam int WbDataW = 32;
  localparam int WbWnW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Everything the access needs while EX/MEM may still change under us.
  typedef struct packed {
    logic               we;
    logic               memtoreg;
    logic               regwrite;
    logic [WbDataW-1:0] alu_out;
    logic [WbDataW-1:0] wdata;
    logic [WbWnW-1:0]   wn;
  } mem_req_t;

  typedef struct packed {
    logic               valid;
    logic               memtoreg;
    logic               regwrite;
    logic [WbDataW-1:0] rdata;
    logic [WbDataW-1:0] alu_out;
    logic [WbWnW-1:0]   wn;
  } mem_wb_t;

  function automatic logic branch_taken(input logic valid, input logic branch,
                                        input logic beq, input logic zero,
                                        input logic bgtz);
    return valid & branch & (beq ? zero : bgtz);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating cycle counter with clear, load and terminal-count flag; used by
// stage controllers to bound how long they wait on a handshake.
module mem_timeout_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc_o = (count_q == term_val_i);

  // Clear beats load beats count; counting stops at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && !tc_o) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: branch resolution, req/ack data-memory access and the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN turns misaligned loads/stores into faults.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_MemtoReg,
  input  logic               in_RegWrite,
  input  logic               in_MemRead,
  input  logic               in_MemWrite,
  input  logic               in_Branch,
  input  logic               in_Beq,
  input  logic               in_zero,
  input  logic               in_bgtz,
  input  logic [31:0]        in_b_tgt,
  input  logic [31:0]        in_alu_out,
  input  logic [31:0]        in_RD2,
  input  logic [WbWnW-1:0]   in_rfile_wn,
  output logic               stall,
  output logic               pc_src,
  output logic [31:0]        pc_tgt,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [AW-1:0]      dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ack,
  output logic               wb_valid,
  output logic               wb_MemtoReg,
  output logic               wb_RegWrite,
  output logic [WbDataW-1:0] wb_rdata,
  output logic [WbDataW-1:0] wb_alu_out,
  output logic [WbWnW-1:0]   wb_rfile_wn,
  output logic               mem_err
);

  localparam int CtrW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TermVal   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit TimeoutEn = (TIMEOUT > 0);

  mem_state_e   state_q;
  mem_state_e   state_d;
  mem_req_t     req_q;
  mem_req_t     req_d;
  mem_wb_t      wb_q;
  mem_wb_t      wb_d;
  logic [31:0]  rdata_q;
  logic [31:0]  rdata_d;
  logic         err_q;
  logic         err_d;
  logic         pc_src_q;
  logic         pc_src_d;
  logic [31:0]  pc_tgt_q;
  logic [31:0]  pc_tgt_d;

  logic         mem_op;
  logic         accept_mem;
  logic         misalign;
  logic         ctr_tc;
  logic         timeout_hit;

  assign mem_op     = in_MemRead | in_MemWrite;
  assign accept_mem = (state_q == ST_IDLE) & in_valid & mem_op;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (in_alu_out[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Counts ACCESS cycles; its value equals the number of cycles already spent waiting.
  mem_timeout_ctr #(
    .WIDTH (CtrW)
  ) u_timeout_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q != ST_ACCESS),
    .load_i     (1'b0),
    .load_val_i ({CtrW{1'b0}}),
    .en_i       (state_q == ST_ACCESS),
    .term_val_i (CtrW'(TermVal)),
    .tc_o       (ctr_tc)
  );

  assign timeout_hit = TimeoutEn & ctr_tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_mem) begin
          state_d = misalign ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack || timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall covers the accept cycle through the ack cycle; held low while in reset.
  always_comb begin
    stall    = 1'b0;
    dmem_req = (state_q == ST_ACCESS);
    if (!rst) begin
      stall = accept_mem | (state_q == ST_ACCESS);
    end
  end

  always_comb begin
    req_d       = req_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    wb_d        = wb_q;
    wb_d.valid  = 1'b0;
    pc_src_d    = 1'b0;
    pc_tgt_d    = pc_tgt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (branch_taken(in_valid, in_Branch, in_Beq, in_zero, in_bgtz)) begin
          pc_src_d = 1'b1;
          pc_tgt_d = in_b_tgt;
        end
        if (accept_mem) begin
          req_d.we       = in_MemWrite;
          req_d.memtoreg = in_MemtoReg;
          req_d.regwrite = in_RegWrite & ~misalign;
          req_d.alu_out  = in_alu_out;
          req_d.wdata    = in_RD2;
          req_d.wn       = in_rfile_wn;
          rdata_d        = '0;
          if (misalign) begin
            err_d = 1'b1;
          end
        end else if (in_valid) begin
          wb_d = '{valid: 1'b1, memtoreg: in_MemtoReg, regwrite: in_RegWrite,
                   rdata: '0, alu_out: in_alu_out, wn: in_rfile_wn};
        end
      end
      ST_ACCESS: begin
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
        end else if (timeout_hit) begin
          req_d.regwrite = 1'b0;
          err_d          = 1'b1;
        end
      end
      ST_DONE: begin
        wb_d = '{valid: 1'b1, memtoreg: req_q.memtoreg, regwrite: req_q.regwrite,
                 rdata: rdata_q, alu_out: req_q.alu_out, wn: req_q.wn};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      rdata_q  <= '0;
      wb_q     <= '0;
      err_q    <= 1'b0;
      pc_src_q <= 1'b0;
      pc_tgt_q <= '0;
    end else begin
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      wb_q     <= wb_d;
      err_q    <= err_d;
      pc_src_q <= pc_src_d;
      pc_tgt_q <= pc_tgt_d;
    end
  end

  assign pc_src      = pc_src_q;
  assign pc_tgt      = pc_tgt_q;
  assign dmem_we     = req_q.we;
  assign dmem_addr   = {req_q.alu_out[AW-1:2], 2'b00};
  assign dmem_wdata  = req_q.wdata;
  assign wb_valid    = wb_q.valid;
  assign wb_MemtoReg = wb_q.memtoreg;
  assign wb_RegWrite = wb_q.regwrite;
  assign wb_rdata    = wb_q.rdata;
  assign wb_alu_out  = wb_q.alu_out;
  assign wb_rfile_wn = wb_q.wn;
  assign mem_err     = err_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: upstream driver, memory responder and
// output monitors, checked against a transaction-level model of the stage.
module tb_mem_stage_unit;

  localparam int T = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, in_MemtoReg, in_RegWrite, in_MemRead, in_MemWrite;
  logic        in_Branch, in_Beq, in_zero, in_bgtz;
  logic [31:0] in_b_tgt, in_alu_out, in_RD2;
  logic [4:0]  in_rfile_wn;
  logic        stall, pc_src, dmem_req, dmem_we, dmem_ack;
  logic [31:0] pc_tgt, dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_MemtoReg, wb_RegWrite, mem_err;
  logic [31:0] wb_rdata, wb_alu_out;
  logic [4:0]  wb_rfile_wn;

  mem_stage_unit #(.AW(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_MemtoReg(in_MemtoReg),
    .in_RegWrite(in_RegWrite), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_Branch(in_Branch), .in_Beq(in_Beq), .in_zero(in_zero), .in_bgtz(in_bgtz),
    .in_b_tgt(in_b_tgt), .in_alu_out(in_alu_out), .in_RD2(in_RD2),
    .in_rfile_wn(in_rfile_wn), .stall(stall), .pc_src(pc_src), .pc_tgt(pc_tgt),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
    .wb_rdata(wb_rdata), .wb_alu_out(wb_alu_out), .wb_rfile_wn(wb_rfile_wn),
    .mem_err(mem_err)
  );

  typedef struct {
    bit valid, m2r, rw, rd, wr, br, beq, zero, bgtz;
    logic [31:0] tgt, alu, rd2, rdata;
    logic [4:0]  wn;
    int          lat;
  } instr_t;

  typedef struct {
    bit m2r, rw, chkRdata, err;
    logic [31:0] rdata, alu;
    logic [4:0]  wn;
    int          idx;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    bit          we;
    int          lat;
  } mem_exp_t;

  wb_exp_t     wbQ[$];
  mem_exp_t    memQ[$];
  logic [31:0] brQ[$];
  int          consumeCyc[int];
  int          nCompared, nMismatched, cyc, instrIdx;
  bit          errModel, respOn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Write-back monitor: every MEM/WB slot must match the oldest expected result,
  // and appear right after the edge on which the instruction left EX/MEM.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (wbQ.size() == 0) begin
          checkOutput("wb_unexpected", 32'd1, 32'd0);
        end else begin
          e = wbQ.pop_front();
          checkOutput("wb_MemtoReg", 32'(wb_MemtoReg), 32'(e.m2r));
          checkOutput("wb_RegWrite", 32'(wb_RegWrite), 32'(e.rw));
          checkOutput("wb_alu_out", wb_alu_out, e.alu);
          checkOutput("wb_rfile_wn", 32'(wb_rfile_wn), 32'(e.wn));
          if (e.chkRdata) checkOutput("wb_rdata", wb_rdata, e.rdata);
          checkOutput("mem_err", 32'(mem_err), 32'(e.err));
          checkOutput("wb_latency", 32'(cyc),
                      32'(consumeCyc.exists(e.idx) ? consumeCyc[e.idx] : -1));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pc_src === 1'b1) begin
        if (brQ.size() == 0) checkOutput("pc_src_unexpected", 32'd1, 32'd0);
        else checkOutput("pc_tgt", pc_tgt, brQ.pop_front());
      end
    end
  end

  // Memory responder: acks after the chosen number of request cycles, throws
  // spurious acks while no request is up, and checks the request itself.
  initial begin
    mem_exp_t m;
    int       cnt;
    bit       active;
    active = 1'b0;
    cnt = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    m = '{addr: '0, wdata: '0, rdata: '0, we: 1'b0, lat: 1};
    forever begin
      @(negedge clk);
      if (!respOn) begin
        dmem_ack = 1'b0;
        active = 1'b0;
      end else if (dmem_req === 1'b1) begin
        if (!active) begin
          if (memQ.size() == 0) begin
            checkOutput("req_unexpected", 32'd1, 32'd0);
            m = '{addr: '0, wdata: '0, rdata: '0, we: 1'b0, lat: 1};
          end else begin
            m = memQ.pop_front();
          end
          active = 1'b1;
          cnt = 0;
        end
        checkOutput("dmem_addr", dmem_addr, m.addr);
        checkOutput("dmem_we", 32'(dmem_we), 32'(m.we));
        checkOutput("dmem_wdata", dmem_wdata, m.wdata);
        cnt++;
        dmem_ack = (cnt == m.lat);
        dmem_rdata = (cnt == m.lat) ? m.rdata : $urandom;
      end else begin
        if (active) begin
          checkOutput("req_cycles", 32'(cnt), 32'((m.lat <= T) ? m.lat : T));
          active = 1'b0;
        end
        dmem_ack = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  function automatic instr_t blankInstr();
    instr_t i;
    i = '{valid: 1'b0, m2r: 1'b0, rw: 1'b0, rd: 1'b0, wr: 1'b0, br: 1'b0,
          beq: 1'b0, zero: 1'b0, bgtz: 1'b0, tgt: '0, alu: '0, rd2: '0,
          rdata: '0, wn: '0, lat: 1};
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    i = blankInstr();
    i.valid = 1'b1;
    i.m2r = 1'($urandom);  i.rw = 1'($urandom);   i.beq = 1'($urandom);
    i.zero = 1'($urandom); i.bgtz = 1'($urandom);
    i.tgt = $urandom; i.alu = $urandom; i.rd2 = $urandom; i.rdata = $urandom;
    i.wn = 5'($urandom);
    i.lat = $urandom_range(1, 6);
    case ($urandom_range(0, 9))
      0:       begin i.valid = 1'b0; i.rd = 1'($urandom); i.wr = 1'($urandom); i.br = 1'b1; end
      1, 2:    begin i.rd = 1'b1; i.m2r = 1'b1; end
      3:       i.wr = 1'b1;
      4:       begin i.rd = 1'b1; i.wr = 1'b1; end
      5, 6:    i.br = 1'b1;
      default: ;
    endcase
    return i;
  endfunction

  // Presents one instruction as the upstream pipeline would, records what the
  // stage must produce for it, and holds it until stall releases it.
  task automatic applyStimulus(input instr_t ins);
    int       expStall, cycles, myIdx;
    bit       isMem, mis, acked;
    wb_exp_t  w;
    mem_exp_t m;
    myIdx = instrIdx;
    instrIdx++;
    isMem = ins.valid && (ins.rd || ins.wr);
    mis = AlignChk && (ins.alu[1:0] != 2'b00);
    expStall = 0;
    acked = 1'b1;
    if (ins.valid && ins.br && (ins.beq ? ins.zero : ins.bgtz)) brQ.push_back(ins.tgt);
    if (isMem) begin
      if (mis) begin
        expStall = 1;
        acked = 1'b0;
        errModel = 1'b1;
      end else begin
        m.addr = {ins.alu[31:2], 2'b00};
        m.we = ins.wr;
        m.wdata = ins.rd2;
        m.lat = ins.lat;
        m.rdata = ins.rdata;
        memQ.push_back(m);
        acked = (ins.lat <= T);
        expStall = 1 + (acked ? ins.lat : T);
        if (!acked) errModel = 1'b1;
      end
    end
    if (ins.valid) begin
      w.m2r = ins.m2r;
      w.rw = ins.rw && acked;
      w.rdata = ins.rdata;
      w.alu = ins.alu;
      w.wn = ins.wn;
      w.chkRdata = isMem && acked;
      w.err = errModel;
      w.idx = myIdx;
      wbQ.push_back(w);
    end
    in_valid = ins.valid;  in_MemtoReg = ins.m2r; in_RegWrite = ins.rw;
    in_MemRead = ins.rd;   in_MemWrite = ins.wr;  in_Branch = ins.br;
    in_Beq = ins.beq;      in_zero = ins.zero;    in_bgtz = ins.bgtz;
    in_b_tgt = ins.tgt;    in_alu_out = ins.alu;  in_RD2 = ins.rd2;
    in_rfile_wn = ins.wn;
    cycles = 0;
    @(negedge clk);
    while (stall === 1'b1 && cycles <= 40) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput("stall_cycles", 32'(cycles), 32'(expStall));
    @(posedge clk);
    #1;
    consumeCyc[myIdx] = cyc;
  endtask

  initial begin
    instr_t ins;
    nCompared = 0;
    nMismatched = 0;
    instrIdx = 0;
    errModel = 1'b0;
    respOn = 1'b1;
    rst = 1'b1;
    applyZero();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_pc_src", 32'(pc_src), 32'd0);
    checkOutput("rst_pc_tgt", pc_tgt, 32'd0);
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_dmem_we", 32'(dmem_we), 32'd0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    checkOutput("rst_wb_rdata", wb_rdata, 32'd0);
    checkOutput("rst_wb_alu_out", wb_alu_out, 32'd0);
    checkOutput("rst_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed: ALU op, load, branches, alignment, timeout");
    ins = blankInstr(); ins.valid = 1; ins.rw = 1; ins.alu = 32'h1234; ins.wn = 5'd5;
    applyStimulus(ins);
    ins = blankInstr(); ins.valid = 1; ins.rd = 1; ins.m2r = 1; ins.rw = 1;
    ins.alu = 32'h40; ins.wn = 5'd7; ins.lat = 3; ins.rdata = 32'hDEADBEEF;
    applyStimulus(ins);
    ins = blankInstr(); ins.valid = 1; ins.br = 1; ins.beq = 1; ins.zero = 1; ins.tgt = 32'h200;
    applyStimulus(ins);
    ins = blankInstr(); ins.valid = 1; ins.br = 1; ins.beq = 0; ins.bgtz = 0; ins.zero = 1;
    ins.tgt = 32'h300;
    applyStimulus(ins);
    ins = blankInstr(); ins.valid = 1; ins.rd = 1; ins.m2r = 1; ins.rw = 1;
    ins.alu = 32'h41; ins.wn = 5'd9; ins.lat = 2; ins.rdata = 32'h0BADF00D;
    applyStimulus(ins);
    ins = blankInstr(); ins.valid = 1; ins.wr = 1; ins.rw = 1; ins.alu = 32'h80;
    ins.rd2 = 32'hCAFEF00D; ins.lat = 100;
    applyStimulus(ins);
    applyStimulus(blankInstr());

    $display("[TB] directed: reset during access");
    respOn = 1'b0;
    in_valid = 1; in_MemRead = 1; in_MemtoReg = 1; in_RegWrite = 1;
    in_alu_out = 32'h100; in_rfile_wn = 5'd3;
    @(negedge clk);
    checkOutput("rstacc_stall", 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstacc_req_up", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyZero();
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstacc_req", 32'(dmem_req), 32'd0);
    checkOutput("rstacc_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rstacc_stall_after", 32'(stall), 32'd0);
    checkOutput("rstacc_mem_err", 32'(mem_err), 32'd0);
    errModel = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    respOn = 1'b1;
    ins = blankInstr(); ins.valid = 1; ins.rd = 1; ins.m2r = 1; ins.rw = 1;
    ins.alu = 32'h100; ins.wn = 5'd3; ins.lat = 2; ins.rdata = 32'h12345678;
    applyStimulus(ins);

    $display("[TB] random traffic");
    for (int n = 0; n < 150; n++) applyStimulus(randInstr());
    repeat (3) applyStimulus(blankInstr());
    repeat (5) @(negedge clk);
    checkOutput("wbQ_drained", 32'(wbQ.size()), 32'd0);
    checkOutput("memQ_drained", 32'(memQ.size()), 32'd0);
    checkOutput("brQ_drained", 32'(brQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  task automatic applyZero();
    in_valid = 0;  in_MemtoReg = 0; in_RegWrite = 0; in_MemRead = 0; in_MemWrite = 0;
    in_Branch = 0; in_Beq = 0;      in_zero = 0;     in_bgtz = 0;
    in_b_tgt = '0; in_alu_out = '0; in_RD2 = '0;     in_rfile_wn = '0;
  endtask

endmodule
